// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word width, address check.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package dmem_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Misaligned or beyond the array. The full 30-bit word index is compared,
  // so high address bits never alias back into the array.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned      depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array: synchronous write, synchronous read into a clearable output register.
// Latency: read data appears on the edge that samples rd_en; writes land on the same edge.
// Backpressure: none; the caller sequences accesses.
//
// Ports: clk, rst (async active-low, clears rdata only), rd_en/wr_en/clr access strobes,
//        addr word index, wdata store data, rdata registered read data.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int INIT_INDEX = 1,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] words [DEPTH];

  // Contents carry a power-up value only; reset deliberately leaves them alone.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [WORD_W-1:0] word_q = (INIT_INDEX != 0) ? WORD_W'(i) : '0;

    always_ff @(posedge clk) begin
      if (wr_en && (addr == AW'(i))) begin
        word_q <= wdata;
      end
    end

    assign words[i] = word_q;
  end

  // Read has priority; clr zeroes the register for stores, errors and after the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= words[addr];
    end else if (clr) begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory target: one response (data or ack + error) per accepted request.
// Latency: accept at edge T -> resp_valid sampled high at edge T+LATENCY (LATENCY 1..15).
// Backpressure: one transaction in flight; req_ready low until the response handshakes.
//
// Ports: clk, rst (async active-low); request channel req_valid/req_ready with
//        req_write, req_addr (byte), req_wdata; response channel resp_valid/resp_ready
//        with resp_rdata (0 for stores/errors) and resp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int LATENCY    = 2,
  parameter int INIT_INDEX = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        state, state_nx;
  logic [3:0]        cnt;
  logic              cap_write, cap_err;
  logic [AW-1:0]     cap_idx;
  logic [WORD_W-1:0] cap_wdata;

  logic              accept, hs, commit;
  logic              c_write, c_err;
  logic [AW-1:0]     c_idx;
  logic [WORD_W-1:0] c_wdata;

  assign accept = req_valid && req_ready;
  assign hs     = resp_valid && resp_ready;

  // With LATENCY == 1 the commit edge is the accept edge, so the commit has to
  // see the live request rather than the (not yet loaded) captured copy.
  assign c_write = (state == IDLE) ? req_write                 : cap_write;
  assign c_err   = (state == IDLE) ? addr_err(req_addr, DEPTH) : cap_err;
  assign c_idx   = (state == IDLE) ? req_addr[AW+1:2]          : cap_idx;
  assign c_wdata = (state == IDLE) ? req_wdata                 : cap_wdata;

  // The memory access happens exactly once, on the edge that enters RESP.
  assign commit = (state != RESP) && (state_nx == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= req_write;
        cap_err   <= addr_err(req_addr, DEPTH);
        cap_idx   <= req_addr[AW+1:2];
        cap_wdata <= req_wdata;
        if (LATENCY > 1) begin
          cnt <= 4'(LATENCY - 2);
        end
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if (commit) begin
        resp_err <= c_err;
      end else if (hs) begin
        resp_err <= 1'b0;
      end
    end
  end

  // Errored accesses touch nothing; the clear strobe zeroes rdata for them and for stores.
  dmem_array #(
    .DEPTH      (DEPTH),
    .INIT_INDEX (INIT_INDEX)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .rd_en (commit && !c_write && !c_err),
    .wr_en (commit &&  c_write && !c_err),
    .clr   (commit || hs),
    .addr  (c_idx),
    .wdata (c_wdata),
    .rdata (resp_rdata)
  );

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the load/store stage of the pipelined MIPS core.
- Replaces the combinational data-memory array with a handshaked responder that has a configurable latency.
- The memory stage issues a request (read or write) on a valid/ready channel. The responder returns exactly one response per accepted request (read data or write ack, plus error flag) on a second valid/ready channel.
- Intended as the memory-side end for a future stalling memory stage.

Parameters:
DEPTH, 128, number of 32-bit words; word index = req_addr[31:2].
LATENCY, 2, cycles from the request-accept edge to resp_valid high; legal range 1..15.
INIT_INDEX, 1, when 1 the array powers up with mem[i] = i; when 0 it powers up with all words 0.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-low (0 = reset).
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_write  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data.
resp_valid  output  1  response present.
resp_ready  input  1  requester accepts the response.
resp_rdata  output  32  load data; 0 for stores and errors.
resp_err  output  1  misaligned or out-of-range access.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state == IDLE).
  - resp_valid = (state == RESP).
- Reset (rst = 0, asynchronous):
  - state = IDLE, cnt = 0, resp_rdata = 0, resp_err = 0.
  - Resulting outputs: req_ready = 1, resp_valid = 0.
  - The memory array is not cleared by reset; it is initialised only at power-up.
- IDLE:
  - A request is accepted on an edge where req_valid && req_ready.
  - On acceptance, capture write, addr and wdata.
  - Error check: err = (addr[1:0] != 0) || (addr[31:2] >= DEPTH).
  - If LATENCY == 1, go to RESP; otherwise load cnt = LATENCY-2 and go to WAIT.
- WAIT:
  - cnt decrements by 1 each edge.
  - When cnt == 0, go to RESP on that edge.
- Commit (on the edge that enters RESP):
  - Load with no error: resp_rdata = mem[idx].
  - Store with no error: mem[idx] = wdata; resp_rdata = 0.
  - Any error: no memory access; resp_rdata = 0; resp_err = 1.
  - resp_err is registered at this same edge.
- Latency: accept at edge T gives resp_valid = 1 from edge T+LATENCY.
- RESP:
  - resp_valid, resp_rdata and resp_err stay stable until resp_valid && resp_ready.
  - On that handshake edge, go to IDLE and clear resp_rdata and resp_err to 0.
  - Back-to-back throughput is one request per LATENCY+1 cycles.
  - A response and a new request never handshake on the same edge.
- The requester may drop req_valid before acceptance; nothing is captured.
- Request inputs are ignored outside IDLE.
- Store followed by load to the same address returns the stored value, because commits are strictly ordered.
- Reset asserted in WAIT: the request is discarded and memory is unchanged. The commit edge has not occurred, so no partial store is possible.
- Reset asserted in RESP: the pending response is lost; a store already committed remains in memory.
- Out-of-range check uses the full 30-bit word index. There is no wrap-around: addr 0x200 with DEPTH = 128 is an error.

Decomposition:
- Package dmem_pkg holds:
  - state encoding constants IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  - WORD_W = 32;
  - the error-check function (alignment and range).
- One sub-module, dmem_array: single-port synchronous-write / synchronous-read word array with parameters DEPTH and INIT_INDEX.
- The FSM and latency counter live in dmem_responder.

Test Plan:
1. Reset released, LATENCY = 2, load addr 0x10 held with resp_ready = 1 -> req_ready = 1 after reset; accepted at edge T; resp_valid at T+2 with resp_rdata = 4, resp_err = 0; req_ready = 1 again at T+3.
2. Store addr 0x20 data 0xDEADBEEF, then load 0x20 -> store response rdata = 0, err = 0; load returns 0xDEADBEEF; load of 0x24 returns 9.
3. Load addr 0x13 (misaligned), then store 0x200 (out of range, DEPTH = 128) -> both give resp_err = 1, rdata = 0; a following load of 0x10 returns 4, so memory is unchanged.
4. resp_ready held 0 for 5 cycles after resp_valid, with req_valid = 1 and a new request on the bus -> resp_rdata/err stable, req_ready = 0, new request not accepted until the cycle after the response handshake.
5. Store 0x40 data 0x55 accepted, rst pulled low during WAIT (LATENCY = 4) -> outputs reset immediately (req_ready = 1, resp_valid = 0); a later load of 0x40 returns 16, so no store was committed.
6. LATENCY = 1, load 0x0 -> resp_valid on the edge after acceptance, rdata = 0, err = 0.
